// File: rtl/mat_mul_pkg.sv
// ============================================================================
// mat_mul_pkg : shared FSM encoding and sizing helpers for mat_mul_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package mat_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Sum of N products of two W-bit values never exceeds this width.
  function automatic int acc_w(input int w, input int n);
    return 2 * w + clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mat_mul_mac.sv
// ============================================================================
// mat_mul_mac : one W x W multiply-accumulate step plus result narrowing
// Rev 1.0
// ============================================================================
`default_nettype none

module mat_mul_mac #(
  parameter int W     = 8,
  parameter int ACC_W = 17,
  parameter int SAT   = 0
) (
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [ACC_W-1:0] i_acc,
  output logic [ACC_W-1:0] o_acc,
  output logic [W-1:0]     o_elem
);

  logic [2*W-1:0] w_prod;

  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign o_acc  = i_acc + {{(ACC_W-2*W){1'b0}}, w_prod};

  generate
    if (SAT != 0) begin : g_sat
      assign o_elem = (|o_acc[ACC_W-1:W]) ? {W{1'b1}} : o_acc[W-1:0];
    end else begin : g_trunc
      assign o_elem = o_acc[W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mat_mul_seq.sv
// ============================================================================
// mat_mul_seq : sequential N x N matrix multiplier, one MAC per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mat_mul_seq
  import mat_mul_pkg::*;
#(
  parameter int N   = 2,
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*N*W-1:0] a_in,
  input  logic [N*N*W-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N*W-1:0] r_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NN    = N * N;
  localparam int DW    = NN * W;
  localparam int ACC_W = acc_w(W, N);
  localparam int IDX_W = clog2(N);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [DW-1:0]    r_q, r_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     w_a_elem;
  logic [W-1:0]     w_b_elem;
  logic [W-1:0]     w_mac_elem;
  logic [ACC_W-1:0] w_mac_sum;

  // Operand fetch: A[i][k] and B[k][j], element 0 sits in the MSBs.
  always_comb begin
    w_a_elem = '0;
    w_b_elem = '0;
    for (int e = 0; e < NN; e++) begin
      if (e == int'(i_q) * N + int'(k_q)) w_a_elem = a_q[(NN-1-e)*W +: W];
      if (e == int'(k_q) * N + int'(j_q)) w_b_elem = b_q[(NN-1-e)*W +: W];
    end
  end

  mat_mul_mac #(
    .W     (W),
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_mac (
    .i_a    (w_a_elem),
    .i_b    (w_b_elem),
    .i_acc  (acc_q),
    .o_acc  (w_mac_sum),
    .o_elem (w_mac_elem)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d = w_mac_sum;
        k_d   = k_q + ONE_IDX;
        if (k_q == LAST_IDX) begin
          acc_d = '0;
          k_d   = '0;
          for (int e = 0; e < NN; e++) begin
            if (e == int'(i_q) * N + int'(j_q)) r_d[(NN-1-e)*W +: W] = w_mac_elem;
          end
          j_d = j_q + ONE_IDX;
          if (j_q == LAST_IDX) begin
            j_d = '0;
            i_d = i_q + ONE_IDX;
            if (i_q == LAST_IDX) begin
              i_d     = '0;
              state_d = ST_DONE;
            end
          end
        end
      end

      // First DONE cycle only raises out_valid; the handshake is taken after.
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign r_out     = r_q;

endmodule

`default_nettype wire

// File: tb/tb_mat_mul_seq.sv
// ============================================================================
// tb_mat_mul_seq : scoreboard bench for mat_mul_seq (N=2 trunc/sat, N=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mat_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a2, b2, r2, r2s;
  logic        iv2, or2, ir2, ir2s, ov2, ov2s, bz2, bz2s;
  logic [71:0] a3, b3, r3;
  logic        iv3, or3, ir3, ov3, bz3;

  int vec  = 0;
  int errs = 0;

  logic [127:0] q2[$];
  logic [127:0] q2s[$];
  logic [127:0] q3[$];

  always #5 clk = ~clk;

  mat_mul_seq #(.N(2), .W(8), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .a_in(a2), .b_in(b2), .in_valid(iv2), .in_ready(ir2),
    .r_out(r2), .out_valid(ov2), .out_ready(or2), .busy(bz2));

  mat_mul_seq #(.N(2), .W(8), .SAT(1)) dut2s (
    .clk(clk), .rst_n(rst_n), .a_in(a2), .b_in(b2), .in_valid(iv2), .in_ready(ir2s),
    .r_out(r2s), .out_valid(ov2s), .out_ready(or2), .busy(bz2s));

  mat_mul_seq #(.N(3), .W(8), .SAT(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .a_in(a3), .b_in(b3), .in_valid(iv3), .in_ready(ir3),
    .r_out(r3), .out_valid(ov3), .out_ready(or3), .busy(bz3));

  // Reference matrix product on 8-bit elements, row-major, element 0 in MSBs.
  function automatic logic [127:0] mm(input int n, input logic [127:0] a,
                                      input logic [127:0] b, input bit sat);
    logic [127:0] r;
    logic [7:0]   ea, eb;
    int           s;
    r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          ea = 8'(a >> ((n*n-1-(i*n+k))*8));
          eb = 8'(b >> ((n*n-1-(k*n+j))*8));
          s  = s + int'(ea) * int'(eb);
        end
        if (sat && s > 255) s = 255;
        r = r | (128'(s & 255) << ((n*n-1-(i*n+j))*8));
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept2(input logic [31:0] a, input logic [31:0] b);
    a2  = a;
    b2  = b;
    iv2 = 1'b1;
    q2.push_back(mm(2, {96'b0, a}, {96'b0, b}, 1'b0));
    q2s.push_back(mm(2, {96'b0, a}, {96'b0, b}, 1'b1));
    tick();
    iv2 = 1'b0;
  endtask

  task automatic wait_ov2(output int cyc);
    cyc = 0;
    while (!ov2 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    vec++; if (ir2 !== 1'b1 || bz2 !== 1'b0 || ov2 !== 1'b0) begin
      errs++; $display("FAIL reset_ctrl2: in_ready=%b busy=%b out_valid=%b, required 1 0 0", ir2, bz2, ov2);
    end
    vec++; if (r2 !== 32'h0 || r2s !== 32'h0) begin
      errs++; $display("FAIL reset_rout2: got %h/%h, required 0", r2, r2s);
    end
    vec++; if (ir3 !== 1'b1 || bz3 !== 1'b0 || ov3 !== 1'b0 || r3 !== 72'h0) begin
      errs++; $display("FAIL reset_n3: in_ready=%b busy=%b out_valid=%b r=%h", ir3, bz3, ov3, r3);
    end
  endtask

  task automatic test_basic;
    int cyc;
    logic [127:0] e, es;
    vec++; if (ir2 !== 1'b1) begin
      errs++; $display("FAIL basic_ready: in_ready=%b, required 1", ir2);
    end
    accept2(32'h01020304, 32'h05060708);
    vec++; if (bz2 !== 1'b1 || ir2 !== 1'b0) begin
      errs++; $display("FAIL basic_busy: busy=%b in_ready=%b, required 1 0", bz2, ir2);
    end
    wait_ov2(cyc);
    vec++; if (cyc !== 9) begin
      errs++; $display("FAIL basic_latency: got %0d cycles, required 9", cyc);
    end
    e  = q2.pop_front();
    es = q2s.pop_front();
    vec++; if (r2 !== e[31:0] || r2 !== 32'h13162B32) begin
      errs++; $display("FAIL basic_result: got %h, required %h", r2, e[31:0]);
    end
    vec++; if (ov2s !== 1'b1 || r2s !== es[31:0]) begin
      errs++; $display("FAIL basic_result_sat: valid=%b got %h, required %h", ov2s, r2s, es[31:0]);
    end
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
    vec++; if (ov2 !== 1'b0 || ir2 !== 1'b1 || bz2 !== 1'b0) begin
      errs++; $display("FAIL basic_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", ov2, ir2, bz2);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [127:0] e, es;
    accept2(32'hFFFFFFFF, 32'h01010101);
    wait_ov2(cyc);
    e  = q2.pop_front();
    es = q2s.pop_front();
    vec++; if (cyc !== 9 || r2 !== e[31:0] || r2 !== 32'hFEFEFEFE) begin
      errs++; $display("FAIL ovf_trunc: cyc=%0d got %h, required %h", cyc, r2, e[31:0]);
    end
    vec++; if (ov2s !== 1'b1 || r2s !== es[31:0] || r2s !== 32'hFFFFFFFF) begin
      errs++; $display("FAIL ovf_sat: got %h, required %h", r2s, es[31:0]);
    end
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc;
    bit bad;
    logic [127:0] e;
    accept2(32'h0A0B0C0D, 32'h01020304);
    a2  = 32'h5A5A5A5A;
    b2  = 32'hA5A5A5A5;
    iv2 = 1'b1;
    wait_ov2(cyc);
    e   = q2.pop_front();
    void'(q2s.pop_front());
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ov2 !== 1'b1 || r2 !== e[31:0] || ir2 !== 1'b0) bad = 1'b1;
    end
    vec++; if (bad) begin
      errs++; $display("FAIL bp_hold: out_valid=%b in_ready=%b got %h, required 1 0 %h", ov2, ir2, r2, e[31:0]);
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
    vec++; if (ov2 !== 1'b0 || ir2 !== 1'b1 || r2 !== e[31:0]) begin
      errs++; $display("FAIL bp_release: out_valid=%b in_ready=%b r=%h, required 0 1 %h", ov2, ir2, r2, e[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit pulse;
    logic [127:0] e;
    accept2(32'h02030405, 32'h06070809);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q2.delete();
    q2s.delete();
    vec++; if (ir2 !== 1'b1 || bz2 !== 1'b0 || ov2 !== 1'b0 || r2 !== 32'h0) begin
      errs++; $display("FAIL rstmid_state: in_ready=%b busy=%b out_valid=%b r=%h, required 1 0 0 0", ir2, bz2, ov2, r2);
    end
    pulse = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (ov2 !== 1'b0 || ov2s !== 1'b0) pulse = 1'b1;
    end
    vec++; if (pulse) begin
      errs++; $display("FAIL rstmid_no_pulse: out_valid seen 1, required 0");
    end
    accept2(32'h01020304, 32'h05060708);
    wait_ov2(cyc);
    e = q2.pop_front();
    void'(q2s.pop_front());
    vec++; if (cyc !== 9 || r2 !== e[31:0]) begin
      errs++; $display("FAIL rstmid_after: cyc=%0d got %h, required 9 %h", cyc, r2, e[31:0]);
    end
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
  endtask

  task automatic test_n3;
    int cyc;
    logic [127:0] e;
    a3  = 72'h01_00_00_00_01_00_00_00_01;
    b3  = 72'h01_02_03_04_05_06_07_08_09;
    iv3 = 1'b1;
    q3.push_back(mm(3, {56'b0, a3}, {56'b0, b3}, 1'b0));
    tick();
    iv3 = 1'b0;
    cyc = 0;
    while (!ov3 && cyc < 100) begin
      tick();
      cyc++;
    end
    vec++; if (cyc !== 28) begin
      errs++; $display("FAIL n3_latency: got %0d cycles, required 28", cyc);
    end
    e = q3.pop_front();
    vec++; if (r3 !== e[71:0] || r3 !== 72'h01_02_03_04_05_06_07_08_09) begin
      errs++; $display("FAIL n3_result: got %h, required %h", r3, e[71:0]);
    end
    or3 = 1'b1;
    tick();
    or3 = 1'b0;
    vec++; if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
      errs++; $display("FAIL n3_release: out_valid=%b in_ready=%b, required 0 1", ov3, ir3);
    end
  endtask

  task automatic test_back_to_back;
    int t, n_acc, n_hs;
    int acc_t[2];
    int hs_t[2];
    bit acc, hs, overlap;
    logic [127:0] e, es;
    t = 0; n_acc = 0; n_hs = 0; overlap = 1'b0;
    acc_t[0] = 0; acc_t[1] = 0; hs_t[0] = 0; hs_t[1] = 0;
    a2  = 32'h11223344;
    b2  = 32'h05060708;
    iv2 = 1'b1;
    or2 = 1'b1;
    while (n_hs < 2 && t < 100) begin
      acc = ir2 && iv2;
      hs  = ov2 && or2;
      if (acc && hs) overlap = 1'b1;
      if (acc) begin
        q2.push_back(mm(2, {96'b0, a2}, {96'b0, b2}, 1'b0));
        q2s.push_back(mm(2, {96'b0, a2}, {96'b0, b2}, 1'b1));
        acc_t[n_acc] = t;
        n_acc++;
      end
      if (hs) begin
        e  = q2.pop_front();
        es = q2s.pop_front();
        vec++; if (r2 !== e[31:0] || r2s !== es[31:0]) begin
          errs++; $display("FAIL b2b_result%0d: got %h/%h, required %h/%h", n_hs, r2, r2s, e[31:0], es[31:0]);
        end
        hs_t[n_hs] = t;
        n_hs++;
      end
      tick();
      t++;
      if (acc && n_acc == 1) begin
        a2 = 32'h0F0E0D0C;
        b2 = 32'h10203040;
      end
      if (acc && n_acc == 2) iv2 = 1'b0;
    end
    iv2 = 1'b0;
    or2 = 1'b0;
    vec++; if (n_hs !== 2 || overlap) begin
      errs++; $display("FAIL b2b_count: results=%0d overlap=%b, required 2 0", n_hs, overlap);
    end
    vec++; if (acc_t[1] !== hs_t[0] + 1) begin
      errs++; $display("FAIL b2b_gap: second accept at %0d, required %0d", acc_t[1], hs_t[0] + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a2 = '0; b2 = '0; iv2 = 1'b0; or2 = 1'b0;
    a3 = '0; b3 = '0; iv3 = 1'b0; or3 = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_n3();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mat_mul_seq.md
MAT_MUL_SEQ -- requirements
Module: mat_mul_seq

Interface
REQ-001 SHALL have parameter N, default 2: matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 8: element width in bits, unsigned, legal range 4..16.
REQ-003 SHALL have parameter SAT, default 0: 0 = truncate result elements to the low W bits; 1 = clamp to 2^W-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port a_in, input, N*N*W: matrix A, row-major, element [0][0] in the MSBs, element [N-1][N-1] in the LSBs.
REQ-007 SHALL have port b_in, input, N*N*W: matrix B, same packing as a_in.
REQ-008 SHALL have port in_valid, input, 1: a_in/b_in hold a valid operand pair.
REQ-009 SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-010 SHALL have port r_out, output, N*N*W: result R = A x B, same packing as a_in.
REQ-011 SHALL have port out_valid, output, 1: r_out holds a complete result.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts r_out this cycle.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an input handshake (in_valid & in_ready) SHALL register a_in and b_in, clear the accumulator and all indices, and move to CALC.
REQ-016 SHALL perform exactly one W x W multiply-accumulate per CALC cycle, with loop order i (row), then j (column), then k (innermost); the CALC phase lasts N^3 cycles.
REQ-017 SHALL size the accumulator as 2W + ceil(log2(N)) bits so that it never overflows internally.
REQ-018 SHALL, when k = N-1, write element R[i][j] (truncated or clamped according to SAT) into the result register and clear the accumulator in the same cycle.
REQ-019 SHALL move to DONE after the last MAC and raise out_valid exactly N^3+1 cycles after the accepting edge (9 cycles for N=2).
REQ-020 SHALL hold out_valid and r_out stable in DONE until out_ready is high, and SHALL then return to IDLE with out_valid low on the next cycle.
REQ-021 SHALL ignore in_valid while not in IDLE; changes on a_in and b_in during CALC SHALL NOT affect the result.
REQ-022 SHALL keep r_out at its last value after the output handshake until the next result is written.
REQ-023 SHALL NOT accept a new operand pair in the same cycle as an output handshake; the earliest next acceptance is one cycle later, in IDLE.

Reset
REQ-024 SHALL, on rst_n = 0 at a clock edge, set state to IDLE, out_valid to 0, in_ready to 1 (IDLE), busy to 0, r_out to 0, and the accumulator and indices to 0.
REQ-025 SHALL, on reset asserted during CALC or DONE, abandon the operation silently; no out_valid pulse SHALL follow.

Structure
REQ-026 SHALL take the state encoding, the ACC_W function and a clog2 function from shared package mat_mul_pkg.
REQ-027 SHALL implement the multiply-accumulate datapath (multiplier, adder and the truncate/saturate stage) as sub-module mat_mul_mac, parameterised by W, ACC_W and SAT.

Verification
REQ-028 SHALL check: N=2, W=8, A=32'h01020304, B=32'h05060708 -> r_out=32'h13162B32, out_valid rising 9 cycles after acceptance.
REQ-029 SHALL check overflow handling: A=32'hFFFFFFFF, B=32'h01010101 -> each element 510 -> r_out=32'hFEFEFEFE (SAT=0) and 32'hFFFFFFFF (SAT=1).
REQ-030 SHALL check backpressure: out_ready held low for 5 cycles in DONE -> out_valid and r_out stable, in_ready=0; result consumed on cycle 6, then in_ready=1 one cycle later.
REQ-031 SHALL check reset mid-operation: rst_n low on cycle 4 of CALC -> next cycle IDLE, r_out=0, no out_valid pulse; a following operation returns the correct result.
REQ-032 SHALL check a second configuration: N=3, W=8, A=identity, B=elements 1..9 -> r_out equals b_in, out_valid rising 28 cycles after acceptance.
REQ-033 SHALL check back-to-back operation: two pairs with in_valid held high and out_ready=1 -> two correct results, second acceptance exactly one cycle after the first output handshake.
